i2s_audio_rx: RTL and testbench

- Receive-side I2S deserializer: the other end of the core's I2S audio transmitter (MCLK/4 SCLK, 32-bit slots, 16 active bits MSB-first, LRCK low = left).
- Oversamples asynchronous SCLK/LRCK/SDATA from the audio_adc path in the system clock domain.
- Recovers slot framing and emits stereo sample pairs with a one-cycle valid strobe to core audio logic.

---
 rtl/i2s_audio_rx_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 53 +++++
 rtl/i2s_audio_rx.sv | 157 +++++++++++++++
 tb/tb_i2s_audio_rx.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_audio_rx_pkg.sv
// Shared I2S audio constants, channel/state encodings and the stereo sample type.
package i2s_audio_rx_pkg;

    localparam int unsigned I2S_SLOT_WIDTH   = 32;
    localparam int unsigned I2S_SAMPLE_WIDTH = 16;
    localparam int unsigned I2S_SYNC_STAGES  = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [I2S_SAMPLE_WIDTH-1:0] left;
        logic [I2S_SAMPLE_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/sync_edge_detect.sv
// N-stage synchronizer for WIDTH asynchronous lanes, with an optional
// registered rising-edge pulse on lane 0.
module sync_edge_detect #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned STAGES      = 2,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic             o_rise
);

    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_async;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_sync = r_sync[STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edge
            logic r_dly;
            logic r_rise;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_dly  <= 1'b0;
                    r_rise <= 1'b0;
                end else begin
                    r_dly  <= o_sync[0];
                    r_rise <= o_sync[0] & ~r_dly;
                end
            end

            assign o_rise = r_rise;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_audio_rx.sv
// I2S receive deserializer: oversamples SCLK/LRCK/SDATA, recovers slot
// framing and presents left/right pairs with a one-cycle valid strobe.
module i2s_audio_rx
    import i2s_audio_rx_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int unsigned SLOT_WIDTH   = I2S_SLOT_WIDTH,
    parameter int unsigned SYNC_STAGES  = I2S_SYNC_STAGES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    output logic                    locked,
    output logic                    framing_error
);

    localparam int unsigned      IDX_W    = $clog2(SLOT_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOT_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_WORD = IDX_W'(SAMPLE_WIDTH - 1);

    logic w_tick;
    logic w_sclk_sync_unused;
    logic w_data_rise_unused;
    logic w_lrck_s;
    logic w_sdata_s;

    rx_state_e r_state;
    rx_state_e w_state_next;

    logic [IDX_W-1:0]        r_bit_idx;
    logic [SAMPLE_WIDTH-2:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic                    r_left_ok;
    logic                    r_prev_lrck;
    logic                    r_valid;
    logic                    r_ferr;
    chan_e                   r_cur_chan;

    logic [SAMPLE_WIDTH-1:0] w_word;
    logic w_change;
    logic w_data_tick;
    logic w_in_sample;
    logic w_word_done;
    logic w_overrun;
    logic w_short;

    sync_edge_detect #(
        .WIDTH      (1),
        .STAGES     (SYNC_STAGES),
        .EDGE_DETECT(1'b1)
    ) u_sclk_sync (
        .clock  (clock),
        .reset  (reset),
        .i_async(i2s_sclk),
        .o_sync (w_sclk_sync_unused),
        .o_rise (w_tick)
    );

    sync_edge_detect #(
        .WIDTH      (2),
        .STAGES     (SYNC_STAGES),
        .EDGE_DETECT(1'b0)
    ) u_data_sync (
        .clock  (clock),
        .reset  (reset),
        .i_async({i2s_lrck, i2s_sdata}),
        .o_sync ({w_lrck_s, w_sdata_s}),
        .o_rise (w_data_rise_unused)
    );

    // An LRCK change pre-empts any data handling on the same tick.
    assign w_change    = w_tick & (w_lrck_s != r_prev_lrck);
    assign w_data_tick = w_tick & ~w_change & (r_state == ST_LOCKED);
    assign w_in_sample = (32'(r_bit_idx) < SAMPLE_WIDTH);
    assign w_word_done = w_data_tick & (r_bit_idx == IDX_WORD);
    assign w_overrun   = w_data_tick & (r_bit_idx == IDX_LAST);
    assign w_short     = w_change & (r_state == ST_LOCKED) & (r_bit_idx != IDX_LAST);
    assign w_word      = {r_shift, w_sdata_s};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_change) begin
            w_state_next = ST_LOCKED;
        end
    end

    always_comb begin
        locked        = (r_state == ST_LOCKED);
        sample_left   = r_left;
        sample_right  = r_right;
        sample_valid  = r_valid;
        framing_error = r_ferr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_left_ok   <= 1'b0;
            r_prev_lrck <= 1'b0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_cur_chan  <= CH_LEFT;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= w_short | w_overrun;
            if (w_change) begin
                r_bit_idx   <= '0;
                r_cur_chan  <= chan_e'(w_lrck_s);
                r_prev_lrck <= w_lrck_s;
                if (w_short) begin
                    r_left_ok <= 1'b0;
                end
            end else if (w_data_tick) begin
                if (w_in_sample) begin
                    r_shift <= w_word[SAMPLE_WIDTH-2:0];
                end
                if (w_word_done) begin
                    if (r_cur_chan == CH_LEFT) begin
                        r_left_hold <= w_word;
                        r_left_ok   <= 1'b1;
                    end else if (r_left_ok) begin
                        r_left    <= r_left_hold;
                        r_right   <= w_word;
                        r_valid   <= 1'b1;
                        r_left_ok <= 1'b0;
                    end
                end
                // Overrun holds the index at the last slot bit until LRCK moves.
                if (w_overrun) begin
                    r_left_ok <= 1'b0;
                end else begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: slot-level reference model predicts pair/error
// events and their clock timing relative to each SCLK pin rise.
module tb_i2s_audio_rx;

    localparam int SAMPLE_W = 16;
    localparam int SLOT_W   = 32;
    localparam int LATENCY  = 4;
    localparam int EV_PAIR  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        logic [15:0] l;
        logic [15:0] r;
        int          at;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i2s_sclk = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        locked;
    logic        framing_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit  tk_lrck[$];
    bit  tk_sdata[$];
    int  rise_cyc[$];
    ev_t exp_q[$];
    ev_t obs_q[$];

    logic [15:0] exp_left;
    logic [15:0] exp_right;
    bit          exp_locked;

    i2s_audio_rx u_dut (
        .clock        (clock),
        .reset        (reset),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .locked       (locked),
        .framing_error(framing_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (sample_valid === 1'b1) obs_q.push_back('{EV_PAIR, sample_left, sample_right, cyc});
        if (framing_error === 1'b1) obs_q.push_back('{EV_ERR, 16'h0, 16'h0, cyc});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic clear_run();
        tk_lrck.delete();
        tk_sdata.delete();
        rise_cyc.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        i2s_sclk  = 1'b0;
        i2s_lrck  = 1'b0;
        i2s_sdata = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        clear_run();
    endtask

    // One LRCK run of len ticks; tick j carries data bit (16-j) for j=1..16.
    task automatic add_slot(input bit ch, input int len, input logic [15:0] data, input int first_j);
        for (int j = first_j; j < first_j + len; j++) begin
            tk_lrck.push_back(ch);
            if (j >= 1 && j <= SAMPLE_W) tk_sdata.push_back(data[SAMPLE_W - j]);
            else tk_sdata.push_back(1'b0);
        end
    endtask

    // Slot-level model of a freshly reset receiver fed the queued ticks.
    task automatic run_model();
        int n, start, len, prev_len;
        bit lvl, ch, ok, left_ok;
        logic [15:0] word, hold;
        n = tk_lrck.size();
        start = 0; prev_len = 0; lvl = 1'b0; ok = 1'b0; left_ok = 1'b0; hold = '0;
        exp_left = '0; exp_right = '0;
        while (start < n) begin
            ch  = tk_lrck[start];
            len = 1;
            while (start + len < n && tk_lrck[start + len] == ch) len++;
            if (ch != lvl) begin
                if (ok && prev_len < SLOT_W) begin
                    exp_q.push_back('{EV_ERR, 16'h0, 16'h0, start});
                    left_ok = 1'b0;
                end
                ok  = 1'b1;
                lvl = ch;
            end
            if (ok) begin
                if (len > SAMPLE_W) begin
                    word = '0;
                    for (int j = 1; j <= SAMPLE_W; j++) word[SAMPLE_W - j] = tk_sdata[start + j];
                    if (ch == 1'b0) begin
                        hold    = word;
                        left_ok = 1'b1;
                    end else if (left_ok) begin
                        exp_q.push_back('{EV_PAIR, hold, word, start + SAMPLE_W});
                        exp_left  = hold;
                        exp_right = word;
                        left_ok   = 1'b0;
                    end
                end
                for (int j = SLOT_W; j < len; j++) begin
                    exp_q.push_back('{EV_ERR, 16'h0, 16'h0, start + j});
                    left_ok = 1'b0;
                end
            end
            prev_len = len;
            start += len;
        end
        exp_locked = ok;
    endtask

    // Data/LRCK change with SCLK falling; each half period lasts h clocks.
    task automatic play(input int hmin, input int hmax);
        for (int t = 0; t < tk_lrck.size(); t++) begin
            int h;
            h = int'($urandom_range(hmax, hmin));
            @(negedge clock);
            i2s_sclk  = 1'b0;
            i2s_lrck  = tk_lrck[t];
            i2s_sdata = tk_sdata[t];
            repeat (h) @(negedge clock);
            i2s_sclk = 1'b1;
            rise_cyc.push_back(cyc);
            repeat (h - 1) @(negedge clock);
        end
        @(negedge clock);
        i2s_sclk = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic compare_events(input string name);
        int exp_at;
        for (int i = 0; i < exp_q.size(); i++) begin
            exp_at = rise_cyc[exp_q[i].at] + LATENCY;
            n_checks++;
            if (i >= obs_q.size()) begin
                n_fail++;
                $display("FAIL %s event%0d: missing, required kind=%0d left=%h right=%h at cycle %0d",
                         name, i, exp_q[i].kind, exp_q[i].l, exp_q[i].r, exp_at);
            end else begin
                if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].l !== exp_q[i].l || obs_q[i].r !== exp_q[i].r) begin
                    n_fail++;
                    $display("FAIL %s event%0d: got kind=%0d left=%h right=%h, required kind=%0d left=%h right=%h",
                             name, i, obs_q[i].kind, obs_q[i].l, obs_q[i].r, exp_q[i].kind, exp_q[i].l, exp_q[i].r);
                end
                n_checks++;
                if (obs_q[i].at !== exp_at) begin
                    n_fail++;
                    $display("FAIL %s event%0d timing: got cycle %0d, required cycle %0d", name, i, obs_q[i].at, exp_at);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s event count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        end
        n_checks++;
        if ({sample_left, sample_right} !== {exp_left, exp_right}) begin
            n_fail++;
            $display("FAIL %s held outputs: got %h/%h, required %h/%h", name, sample_left, sample_right, exp_left, exp_right);
        end
        n_checks++;
        if (locked !== exp_locked) begin
            n_fail++;
            $display("FAIL %s locked: got %b, required %b", name, locked, exp_locked);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b1;
        i2s_lrck  = 1'(($urandom));
        i2s_sdata = 1'(($urandom));
        repeat (3) @(negedge clock);
        n_checks++;
        if ({sample_left, sample_right} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset samples: got %h/%h, required 0/0", sample_left, sample_right);
        end
        n_checks++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset sample_valid: got %b, required 0", sample_valid);
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset locked: got %b, required 0", locked);
        end
        n_checks++;
        if (framing_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset framing_error: got %b, required 0", framing_error);
        end
        do_reset();
    endtask

    task automatic test_nominal();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, SLOT_W, 16'hA55A, 0);
            add_slot(1'b1, SLOT_W, 16'h1234, 0);
        end
        run_model();
        play(12, 12);
        compare_events("nominal");
    endtask

    task automatic test_right_first();
        do_reset();
        add_slot(1'b0, 12, 16'h5A5A, 20);
        add_slot(1'b1, SLOT_W, 16'hFFFF, 0);
        add_slot(1'b0, SLOT_W, 16'h0001, 0);
        add_slot(1'b1, SLOT_W, 16'h8000, 0);
        run_model();
        play(12, 12);
        compare_events("right_first");
    endtask

    task automatic test_short_slot();
        do_reset();
        add_slot(1'b1, SLOT_W, 16'h0000, 0);
        add_slot(1'b0, SLOT_W, 16'h1111, 0);
        add_slot(1'b1, SLOT_W, 16'h2222, 0);
        add_slot(1'b0, 20, 16'h3333, 0);
        add_slot(1'b1, SLOT_W, 16'h4444, 0);
        add_slot(1'b0, SLOT_W, 16'h5555, 0);
        add_slot(1'b1, SLOT_W, 16'h6666, 0);
        run_model();
        play(12, 12);
        compare_events("short_slot");
    endtask

    task automatic test_long_slot();
        do_reset();
        add_slot(1'b1, SLOT_W, 16'h0000, 0);
        add_slot(1'b0, SLOT_W, 16'h1111, 0);
        add_slot(1'b1, SLOT_W, 16'h2222, 0);
        add_slot(1'b0, 40, 16'hABCD, 0);
        add_slot(1'b1, SLOT_W, 16'h0BAD, 0);
        add_slot(1'b0, SLOT_W, 16'h1357, 0);
        add_slot(1'b1, SLOT_W, 16'h2468, 0);
        run_model();
        play(12, 12);
        compare_events("long_slot");
    endtask

    task automatic test_reset_mid();
        do_reset();
        add_slot(1'b1, SLOT_W, 16'h0000, 0);
        add_slot(1'b0, SLOT_W, 16'h4242, 0);
        add_slot(1'b1, SLOT_W, 16'h2424, 0);
        add_slot(1'b0, SLOT_W, 16'h7777, 0);
        add_slot(1'b1, 10, 16'h9999, 0);
        run_model();
        play(12, 12);
        compare_events("reset_mid_pre");
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({sample_left, sample_right} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid samples: got %h/%h, required 0/0", sample_left, sample_right);
        end
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid locked: got %b, required 0", locked);
        end
        reset = 1'b0;
        clear_run();
        add_slot(1'b1, 22, 16'h9999, 10);
        add_slot(1'b0, SLOT_W, 16'h1357, 0);
        add_slot(1'b1, SLOT_W, 16'h2468, 0);
        run_model();
        play(12, 12);
        compare_events("reset_mid_post");
    endtask

    task automatic test_latency();
        do_reset();
        add_slot(1'b1, SLOT_W, 16'h0000, 0);
        add_slot(1'b0, SLOT_W, 16'h0F0F, 0);
        add_slot(1'b1, SLOT_W, 16'hF0F0, 0);
        run_model();
        play(12, 12);
        compare_events("latency_frame");
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL latency: got no sample_valid, required %0d clocks", LATENCY);
        end else if (obs_q[0].at - rise_cyc[2 * SLOT_W + SAMPLE_W] !== LATENCY) begin
            n_fail++;
            $display("FAIL latency: got %0d clocks, required %0d", obs_q[0].at - rise_cyc[2 * SLOT_W + SAMPLE_W], LATENCY);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        logic [15:0] d;
        do_reset();
        add_slot(1'b1, SLOT_W, 16'h0000, 0);
        for (int s = 0; s < 14; s++) begin
            len = ($urandom_range(9, 0) < 7) ? SLOT_W : int'($urandom_range(40, 12));
            d   = 16'($urandom);
            add_slot(bit'(s % 2), len, d, 0);
        end
        run_model();
        play(2, 12);
        compare_events("back_to_back");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_right_first();
        test_short_slot();
        test_long_slot();
        test_reset_mid();
        test_latency();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
